// File: rtl/skein_msg_feeder.sv
// skein_msg_feeder: packs a byte stream into 16-bit Skein-256 host words, pads and tags each block, then fetches the digest.
// Optional feature: define SKEIN_FEEDER_TIMEOUT_EN to abort WAIT_ACK after ACK_TIMEOUT cycles with a sticky err.
module skein_msg_feeder #(
    parameter int BLOCK_WORDS  = 16,
    parameter int DIGEST_WORDS = 16,
    parameter int ACK_TIMEOUT  = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        empty,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        s_ready,
    output logic        init,
    output logic        load,
    output logic [15:0] idata,
    input  logic        ack,
    output logic        fetch,
    input  logic [15:0] odata,
    output logic        d_valid,
    output logic [15:0] d_data,
    output logic        done,
    output logic        err
);
    typedef enum logic [3:0] {IDLE, INIT, FILL, PAD, CTRL, WAIT_ACK, FETCH, DRAIN, DONE} state_t;
    localparam logic [4:0] LAST_WORD = 5'(BLOCK_WORDS - 1);
    localparam logic [4:0] FETCH_N   = 5'(DIGEST_WORDS);
    state_t     state;
    logic [7:0] hi;
    logic [5:0] bcnt;
    logic [4:0] wcnt;
    logic [4:0] fcnt;
    logic       first;
    logic       last;
    logic       fetch_q;
    logic       take;
    assign take = s_valid & s_ready;
    if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 1023) begin : g_bad_timeout
        $error("ACK_TIMEOUT must fit the 10-bit wait counter (1..1023)");
    end
`ifdef SKEIN_FEEDER_TIMEOUT_EN
    localparam logic [9:0] TMO_LAST = 10'(ACK_TIMEOUT - 1);
    logic [9:0] tcnt;
`else
    assign err = 1'b0;
`endif
    // Whole feeder FSM with registered outputs; the odata pipeline trails fetch by two cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            hi      <= '0;
            bcnt    <= '0;
            wcnt    <= '0;
            fcnt    <= '0;
            first   <= 1'b0;
            last    <= 1'b0;
            fetch_q <= 1'b0;
            s_ready <= 1'b0;
            init    <= 1'b0;
            load    <= 1'b0;
            idata   <= '0;
            fetch   <= 1'b0;
            d_valid <= 1'b0;
            d_data  <= '0;
            done    <= 1'b0;
`ifdef SKEIN_FEEDER_TIMEOUT_EN
            tcnt    <= '0;
            err     <= 1'b0;
`endif
        end else begin
            init    <= 1'b0;
            load    <= 1'b0;
            done    <= 1'b0;
            fetch_q <= fetch;
            d_valid <= fetch_q;
            if (fetch_q) d_data <= odata;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= INIT;
                        init  <= 1'b1;
                        last  <= empty;
`ifdef SKEIN_FEEDER_TIMEOUT_EN
                        err   <= 1'b0;
`endif
                    end
                end
                INIT: begin
                    first   <= 1'b1;
                    bcnt    <= '0;
                    wcnt    <= '0;
                    s_ready <= ~last;
                    state   <= last ? PAD : FILL;
                end
                FILL: begin
                    if (take) begin
                        bcnt <= bcnt + 6'd1;
                        if (!bcnt[0] && !s_last) begin
                            hi <= s_data;
                        end else begin
                            load  <= 1'b1;
                            idata <= bcnt[0] ? {hi, s_data} : {s_data, 8'h00};
                            wcnt  <= wcnt + 5'd1;
                            if (s_last) last <= 1'b1;
                            if (wcnt == LAST_WORD || s_last) s_ready <= 1'b0;
                            if (wcnt == LAST_WORD) state <= CTRL;
                            else if (s_last) state <= PAD;
                        end
                    end
                end
                PAD: begin
                    load  <= 1'b1;
                    idata <= '0;
                    wcnt  <= wcnt + 5'd1;
                    if (wcnt == LAST_WORD) state <= CTRL;
                end
                CTRL: begin
                    load  <= 1'b1;
                    idata <= {last, first, 8'h00, bcnt};
                    state <= WAIT_ACK;
`ifdef SKEIN_FEEDER_TIMEOUT_EN
                    tcnt  <= '0;
`endif
                end
                WAIT_ACK: begin
                    if (ack) begin
                        if (last) begin
                            state <= FETCH;
                            fetch <= 1'b1;
                            fcnt  <= 5'd1;
                        end else begin
                            state   <= FILL;
                            s_ready <= 1'b1;
                            first   <= 1'b0;
                            bcnt    <= '0;
                            wcnt    <= '0;
                        end
                    end
`ifdef SKEIN_FEEDER_TIMEOUT_EN
                    else if (tcnt == TMO_LAST) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + 10'd1;
                    end
`endif
                end
                FETCH: begin
                    if (fcnt == FETCH_N) begin
                        fetch <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        fcnt <= fcnt + 5'd1;
                    end
                end
                DRAIN: state <= DONE;
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/skein_msg_feeder.md
# skein_msg_feeder

Upstream host-side feeder for the Skein-256 hash top level. It accepts a byte-serial message stream and packs it into the 16-bit word protocol that the hash core's host interface consumes (`init`/`load`/`idata`/`ack`). It zero-pads the final block, appends a per-block control word, and waits for block completion. After the last block it issues `fetch` cycles and returns the 256-bit digest as 16 sequential 16-bit words.

## Interface
Parameters:
- `BLOCK_WORDS`, 16: 16-bit words per message block (256-bit block).
- `DIGEST_WORDS`, 16: 16-bit words fetched per digest.
- `ACK_TIMEOUT`, 1023: maximum cycles spent in WAIT_ACK. Used only with `SKEIN_FEEDER_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse in IDLE that begins a message; ignored in all other states.
- `empty` in 1: sampled with `start`; 1 means a zero-length message.
- `s_valid` in 1, `s_data` in 8, `s_last` in 1: message byte stream; `s_last` marks the final byte.
- `s_ready` out 1: byte accepted when `s_valid & s_ready`.
- `init` out 1: one-cycle pulse to the core that starts a new hash.
- `load` out 1: one-cycle strobe that qualifies `idata`.
- `idata` out 16: message or control word.
- `ack` in 1: one-cycle pulse from the core when a block has been absorbed.
- `fetch` out 1: digest read strobe; `odata` is valid on the cycle after each `fetch`.
- `odata` in 16: digest word from the core.
- `d_valid` out 1, `d_data` out 16: digest words, 16 consecutive cycles, no backpressure.
- `done` out 1: one-cycle pulse after the last digest word.
- `err` out 1: sticky timeout flag, cleared by `start`; tied 0 without the macro.

## Operation
- States: IDLE, INIT, FILL, PAD, CTRL, WAIT_ACK, FETCH, DRAIN, DONE.
- IDLE -> INIT on `start`. INIT drives `init=1` for one cycle, clears counters, sets `first=1`, then goes to FILL. If `empty=1`, it goes to PAD instead.
- FILL: `s_ready=1`.
  - Even-position byte: latched into `hi`.
  - Odd-position byte: on the next cycle, `load=1` and `idata={hi,byte}` (first byte in [15:8]).
  - `bcnt` (6-bit) counts bytes in the current block; `wcnt` (5-bit) counts words issued.
- `s_last` on an even-position byte: emit `{byte,8'h00}` as the word, then set `last`.
- Block full (`wcnt==BLOCK_WORDS`): `s_ready=0`, go to CTRL.
- `s_last` with a partial block: go to PAD.
- PAD: issue `load` with `idata=16'h0000` each cycle until `wcnt==BLOCK_WORDS`, then go to CTRL.
- CTRL: one `load` with `idata = {last,first,8'h00,bcnt[5:0]}`. `bcnt` is 1..32, or 0 only for an empty message. Then go to WAIT_ACK.
- WAIT_ACK: on `ack`:
  - If `last`, go to FETCH.
  - Otherwise clear `first`, `bcnt`, and `wcnt`, and go to FILL.
- A 32-byte block ending on `s_last` is final. There is no extra padding block.
- FETCH: `fetch=1` for `DIGEST_WORDS` consecutive cycles. Each returned `odata` is registered to `d_data` with `d_valid=1`. DRAIN covers the final returned word.
- DONE: `done=1` for one cycle, then go to IDLE.
- `ack` outside WAIT_ACK is ignored. `s_valid` outside FILL is not accepted.

## Timing
- Reset values: all outputs 0 (`s_ready`, `init`, `load`, `idata`, `fetch`, `d_valid`, `d_data`, `done`, `err`). State is IDLE.
- Reset mid-operation aborts immediately. No `fetch` or `done` is issued afterwards. The core is re-initialised by the next `init`.
- All outputs are registered.
- `start` to `init`: 1 cycle. `init` to earliest `s_ready`: 1 cycle.
- Odd byte accepted at cycle t: `load` at t+1.
- At most one `load` every 2 cycles in FILL; one per cycle in PAD and CTRL.
- Last data or pad word at t: CTRL word at t+1.
- `ack` at t: `s_ready` (next block) or first `fetch` at t+1.
- `fetch` at t: `odata` sampled at t+1, `d_valid` at t+2.
- First `fetch` at t: `done` at t+`DIGEST_WORDS`+2.
- `s_last` coinciding with block full: CTRL with `last=1`, no PAD cycles.

## Configuration
- `SKEIN_FEEDER_TIMEOUT_EN` defined: a 10-bit counter runs in WAIT_ACK. When it reaches `ACK_TIMEOUT` without `ack`, it sets `err=1` and returns to IDLE with no `fetch` and no `done`. `err` stays set until the next accepted `start`.
- `SKEIN_FEEDER_TIMEOUT_EN` undefined: WAIT_ACK waits indefinitely, and `err` is constant 0.

## Test plan
- 1-byte message 0x61: `init`, then words 0x6100 followed by 15 × 0x0000, then CTRL 0xC001. After `ack`, 16 `fetch` cycles, 16 `d_valid` words matching `odata`, then `done`.
- 32 bytes 0x00..0x1F: 16 words 0x0001..0x1E1F, then CTRL 0xC020, with no PAD cycles.
- 33 bytes: block 1 CTRL 0x4020. After `ack`, block 2 is word 0x2000, 15 zero words, then CTRL 0x8001.
- `start` with `empty=1`: 16 zero words, then CTRL 0xC000, then a normal digest fetch.
- `rst` asserted mid-FILL at word 7: all outputs 0 on the next edge. A new `start` produces a clean `init` and the sequence restarts at word 0.
- With `SKEIN_FEEDER_TIMEOUT_EN` and `ACK_TIMEOUT=20`, withhold `ack`: `err=1` 20 cycles after CTRL, state returns to IDLE, no `fetch`. The next `start` clears `err`.
